usb_mem_bist: RTL and testbench

Synthesisable self-checking memory sequencer for the USB host data path. It drives the host transaction port with the four-pass memory check the team runs on every build: uninitialised read, write/read-back, reread, and rewrite/read-back. It is generalised in data width, address width, address count and address stride, and reports per-pass verdicts, an error count and the first failing address. It sits between the system controller and the host request port, in place of bench-driven read/write tasks.

---
 rtl/usb_mem_bist.sv | 212 +++++++++++++++++++++
 tb/tb_usb_mem_bist.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_mem_bist.sv
// Four-pass memory check sequencer for the USB host transaction port.
// Define USB_MEM_BIST_TIMEOUT_EN to add an ack watchdog that scores a stalled transaction as a failure.
module usb_mem_bist #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned N_ADDR  = 8,
    parameter logic [ADDR_W-1:0] START  = '0,
    parameter logic [ADDR_W-1:0] STRIDE = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] MAGIC  = ADDR_W'(16'hBABE),
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              start,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              ack,
    input  logic              success,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [3:0]        phase_pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [1:0]        first_err_phase
);

    localparam int unsigned REP      = DATA_W / ADDR_W;
    localparam logic [15:0] LAST_IDX = 16'(N_ADDR - 1);

    // WAIT is the only state with a request outstanding; it is entered on the edge that raises req.
    typedef enum logic [1:0] {IDLE, WAIT, GAP, DONE} state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          pass_q, pass_d;
    logic [15:0]         idx_q, idx_d;
    logic                last_q, last_d;
    logic [3:0]          phase_q, phase_d;
    logic [15:0]         err_q, err_d;
    logic [ADDR_W-1:0]   fea_q, fea_d;
    logic [1:0]          fep_q, fep_d;
    logic                fail;
    logic                xferEnd;
    logic                timedOut;
`ifdef USB_MEM_BIST_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0]     wdog_q, wdog_d;
`endif

    function automatic logic [DATA_W-1:0] fill(input logic [ADDR_W-1:0] a);
        return {REP{a}};
    endfunction

    // Pass 0 expects erased memory, passes 1-2 the MAGIC-keyed pattern, pass 3 the plain address.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] p, input logic [ADDR_W-1:0] a);
        case (p)
            2'd0:    return '0;
            2'd3:    return fill(a);
            default: return fill(a ^ MAGIC);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pass_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            phase_q <= 4'hF;
            err_q   <= '0;
            fea_q   <= '0;
            fep_q   <= '0;
`ifdef USB_MEM_BIST_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pass_q  <= pass_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
            fep_q   <= fep_d;
`ifdef USB_MEM_BIST_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pass_d   = pass_q;
        idx_d    = idx_q;
        last_d   = last_q;
        phase_d  = phase_q;
        err_d    = err_q;
        fea_d    = fea_q;
        fep_d    = fep_q;
        fail     = 1'b0;
        xferEnd  = 1'b0;
        timedOut = 1'b0;
`ifdef USB_MEM_BIST_TIMEOUT_EN
        wdog_d   = wdog_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = START;
                    wdata_d = '0;
                    pass_d  = '0;
                    idx_d   = '0;
                    last_d  = 1'b0;
                    phase_d = 4'hF;
                    err_d   = '0;
                    fea_d   = '0;
                    fep_d   = '0;
`ifdef USB_MEM_BIST_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            WAIT: begin
`ifdef USB_MEM_BIST_TIMEOUT_EN
                if (!ack) begin
                    if (wdog_q == WD_W'(TIMEOUT - 1)) timedOut = 1'b1;
                    else wdog_d = wdog_q + 1'b1;
                end
`endif
                xferEnd = ack || timedOut;
                if (xferEnd) begin
                    fail = !ack || !success || (!we_q && (rdata != pattern(pass_q, addr_q)));
                    if (fail) begin
                        phase_d[pass_q] = 1'b0;
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0) begin
                            fea_d = addr_q;
                            fep_d = pass_q;
                        end
                    end
                    req_d   = 1'b0;
                    state_d = GAP;
`ifdef USB_MEM_BIST_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                    // A write is always followed by its read-back at the same address.
                    if (we_q) begin
                        we_d = 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        if (pass_q == 2'd3) begin
                            last_d = 1'b1;
                        end else begin
                            pass_d = pass_q + 2'd1;
                            idx_d  = '0;
                            addr_d = START;
                            we_d   = pass_d[0];
                        end
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        addr_d = addr_q + STRIDE;
                        we_d   = pass_q[0];
                    end
                    wdata_d = we_d ? pattern(pass_d, addr_d) : '0;
                end
            end
            GAP: begin
                if (last_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req             = req_q;
    assign we              = we_q;
    assign addr            = addr_q;
    assign wdata           = wdata_q;
    assign busy            = (state_q == WAIT) || (state_q == GAP);
    assign done            = (state_q == DONE);
    assign pass            = (state_q == DONE) && (&phase_q);
    assign phase_pass      = phase_q;
    assign err_cnt         = err_q;
    assign first_err_addr  = fea_q;
    assign first_err_phase = fep_q;

endmodule

// File: tb/tb_usb_mem_bist.sv
// Directed bench for usb_mem_bist: three instances share one host memory model.
// Instance 0 uses defaults, 1 starts at 0xFFF9 to cross the wrap, 2 starts at 0x0010 for the watchdog runs.
module tb_usb_mem_bist;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_L;
    logic        startV[NI];
    logic        reqV[NI];
    logic        weV[NI];
    logic [15:0] addrV[NI];
    logic [63:0] wdataV[NI];
    logic        ackV[NI];
    logic        successV[NI];
    logic [63:0] rdataV[NI];
    logic        busyV[NI];
    logic        doneV[NI];
    logic        passV[NI];
    logic [3:0]  phaseV[NI];
    logic [15:0] errV[NI];
    logic [15:0] feaV[NI];
    logic [1:0]  fepV[NI];

    int checkCount = 0;
    int errorCount = 0;

    // Controls written only by the main sequence
    int maxDelay  = 0;
    int failTxn   = -1;
    int memCmd    = 0;
    bit injectAck = 1'b0;
    int injectIdx = 0;

    // State owned by the host model
    logic [63:0] mem [logic [17:0]];
    logic [63:0] w2[$];
    int   waitCnt[NI];
    int   txnCnt[NI];
    int   hiCnt[NI];
    int   lowCnt[NI];
    bit   prevReq[NI];
    bit   prevBusy[NI];
    bit   inRun[NI];
    logic [15:0] latAddr[NI];
    logic        latWe[NI];
    logic [63:0] latWdata[NI];
    int   protoErr = 0;
    int   gapErr   = 0;
    int   toSeen   = 0;
    int   toErr    = 0;
    bit   stuckSet = 1'b0;
    bit   sawZero  = 1'b0;

    always #5 clk = ~clk;

    usb_mem_bist #(.TIMEOUT(4)) dut0 (
        .clk(clk), .rst_L(rst_L), .start(startV[0]), .req(reqV[0]), .we(weV[0]),
        .addr(addrV[0]), .wdata(wdataV[0]), .ack(ackV[0]), .success(successV[0]),
        .rdata(rdataV[0]), .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
        .phase_pass(phaseV[0]), .err_cnt(errV[0]), .first_err_addr(feaV[0]),
        .first_err_phase(fepV[0]));

    usb_mem_bist #(.START(16'hFFF9), .STRIDE(16'h0001), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst_L(rst_L), .start(startV[1]), .req(reqV[1]), .we(weV[1]),
        .addr(addrV[1]), .wdata(wdataV[1]), .ack(ackV[1]), .success(successV[1]),
        .rdata(rdataV[1]), .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
        .phase_pass(phaseV[1]), .err_cnt(errV[1]), .first_err_addr(feaV[1]),
        .first_err_phase(fepV[1]));

    usb_mem_bist #(.START(16'h0010), .TIMEOUT(4)) dut2 (
        .clk(clk), .rst_L(rst_L), .start(startV[2]), .req(reqV[2]), .we(weV[2]),
        .addr(addrV[2]), .wdata(wdataV[2]), .ack(ackV[2]), .success(successV[2]),
        .rdata(rdataV[2]), .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]),
        .phase_pass(phaseV[2]), .err_cnt(errV[2]), .first_err_addr(feaV[2]),
        .first_err_phase(fepV[2]));

    // Host model: acks at the falling edge so the DUT samples ack on the next rising edge.
    // It also watches req stability, the single gap cycle and watchdog drop timing.
    initial begin
        for (int i = 0; i < NI; i++) begin
            ackV[i] = 1'b0; successV[i] = 1'b0; rdataV[i] = '0;
            waitCnt[i] = 0; txnCnt[i] = 0; hiCnt[i] = 0; lowCnt[i] = 0;
            prevReq[i] = 1'b0; prevBusy[i] = 1'b0; inRun[i] = 1'b0;
            latAddr[i] = '0; latWe[i] = 1'b0; latWdata[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (busyV[i] && !prevBusy[i]) begin
                    txnCnt[i] = 0;
                    inRun[i]  = 1'b0;
                    if (memCmd >= 1) begin
                        mem.delete();
                        w2.delete();
                        stuckSet = 1'b0;
                        sawZero  = 1'b0;
                    end
                    if (memCmd == 2) mem[{2'd0, 16'h0001}] = 64'hDEAD;
                end
                prevBusy[i] = busyV[i];
                ackV[i] = 1'b0;
                if (reqV[i]) begin
                    if (!prevReq[i]) begin
                        if (inRun[i] && lowCnt[i] != 1) gapErr++;
                        hiCnt[i] = 0;
                        latAddr[i] = addrV[i]; latWe[i] = weV[i]; latWdata[i] = wdataV[i];
                    end else if (addrV[i] != latAddr[i] || weV[i] != latWe[i] || wdataV[i] != latWdata[i]) begin
                        protoErr++;
                    end
                    hiCnt[i]++;
                    lowCnt[i] = 0;
                    inRun[i]  = 1'b1;
                    if (waitCnt[i] > 0) begin
                        waitCnt[i]--;
                    end else if (!(i == 2 && addrV[i] == 16'h0012)) begin
                        ackV[i]     = 1'b1;
                        successV[i] = !(i == 0 && txnCnt[i] == failTxn);
                        if (weV[i]) begin
                            if (!(i == 1 && addrV[i] == 16'hFFFF && stuckSet))
                                mem[{2'(i), addrV[i]}] = wdataV[i];
                            if (i == 1 && addrV[i] == 16'hFFFF) stuckSet = 1'b1;
                            if (i == 0 && addrV[i] == 16'h0002) w2.push_back(wdataV[i]);
                        end else begin
                            rdataV[i] = mem.exists({2'(i), addrV[i]}) ? mem[{2'(i), addrV[i]}] : 64'd0;
                        end
                        if (i == 1 && addrV[i] == 16'h0000) sawZero = 1'b1;
                        txnCnt[i]++;
                        waitCnt[i] = (maxDelay > 0) ? int'($urandom_range(maxDelay, 0)) : 0;
                    end
                end else begin
                    if (prevReq[i] && i == 2 && latAddr[i] == 16'h0012) begin
                        toSeen++;
                        if (hiCnt[i] != 4) toErr++;
                    end
                    lowCnt[i]++;
                    ackV[i] = injectAck && (i == injectIdx);
                end
                prevReq[i] = reqV[i];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int i);
        @(negedge clk);
        startV[i] = 1'b1;
        @(posedge clk);
        #1 startV[i] = 1'b0;
    endtask

    task automatic waitDone(input int i, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1 cycles++;
        end while (!doneV[i] && cycles < 3000);
        checkOutput("done_seen", 64'(doneV[i]), 64'd1);
    endtask

    task automatic lateAck(input int i);
        injectIdx = i;
        @(negedge clk);
        injectAck = 1'b1;
        repeat (4) @(posedge clk);
        #1 injectAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    int cyc;
    bit stopWait;

    initial begin
        for (int i = 0; i < NI; i++) startV[i] = 1'b0;
        rst_L = 1'b0;
        #23;
        checkOutput("rst_req",   64'(reqV[0]),   64'd0);
        checkOutput("rst_busy",  64'(busyV[0]),  64'd0);
        checkOutput("rst_done",  64'(doneV[0]),  64'd0);
        checkOutput("rst_pass",  64'(passV[0]),  64'd0);
        checkOutput("rst_phase", 64'(phaseV[0]), 64'hF);
        checkOutput("rst_err",   64'(errV[0]),   64'd0);
        checkOutput("rst_addr",  64'(addrV[0]),  64'd0);
        checkOutput("rst_wdata", wdataV[0],      64'd0);
        @(negedge clk);
        rst_L = 1'b1;

        $display("[TB] clean run, zero-wait");
        memCmd = 1;
        applyStimulus(0);
        checkOutput("t1_busy", 64'(busyV[0]), 64'd1);
        checkOutput("t1_req",  64'(reqV[0]),  64'd1);
        waitDone(0, cyc);
        checkOutput("t1_cycles", 64'(cyc),       64'd96);
        checkOutput("t1_busy_end", 64'(busyV[0]), 64'd0);
        checkOutput("t1_pass",  64'(passV[0]),  64'd1);
        checkOutput("t1_phase", 64'(phaseV[0]), 64'hF);
        checkOutput("t1_err",   64'(errV[0]),   64'd0);
        checkOutput("t1_txns",  64'(txnCnt[0]), 64'd48);
        checkOutput("t1_w2_count", 64'(w2.size()), 64'd2);
        if (w2.size() == 2) begin
            checkOutput("t1_w2_p1", w2[0], 64'hBABCBABCBABCBABC);
            checkOutput("t1_w2_p3", w2[1], 64'h0002000200020002);
        end
        lateAck(0);
        checkOutput("t1_late_done", 64'(doneV[0]), 64'd1);
        checkOutput("t1_late_req",  64'(reqV[0]),  64'd0);
        checkOutput("t1_late_err",  64'(errV[0]),  64'd0);

        $display("[TB] preloaded 0xDEAD at 0x0001");
        memCmd = 2;
        applyStimulus(0);
        checkOutput("t2_done_cleared", 64'(doneV[0]), 64'd0);
        waitDone(0, cyc);
        checkOutput("t2_phase", 64'(phaseV[0]), 64'hE);
        checkOutput("t2_err",   64'(errV[0]),   64'd1);
        checkOutput("t2_fea",   64'(feaV[0]),   64'h0001);
        checkOutput("t2_fep",   64'(fepV[0]),   64'd0);
        checkOutput("t2_pass",  64'(passV[0]),  64'd0);

        $display("[TB] stuck-at-first-write at 0xFFFF across the wrap");
        memCmd = 1;
        applyStimulus(1);
        waitDone(1, cyc);
        checkOutput("t3_cycles", 64'(cyc),       64'd96);
        checkOutput("t3_phase",  64'(phaseV[1]), 64'h7);
        checkOutput("t3_err",    64'(errV[1]),   64'd1);
        checkOutput("t3_fea",    64'(feaV[1]),   64'hFFFF);
        checkOutput("t3_fep",    64'(fepV[1]),   64'd3);
        checkOutput("t3_pass",   64'(passV[1]),  64'd0);
        checkOutput("t3_wrap",   64'(sawZero),   64'd1);

        $display("[TB] random ack delay, success dropped on 5th transaction");
        memCmd   = 1;
        maxDelay = 7;
        failTxn  = 4;
        applyStimulus(0);
        waitDone(0, cyc);
        checkOutput("t4_err",   64'(errV[0]),   64'd1);
        checkOutput("t4_phase", 64'(phaseV[0]), 64'hE);
        checkOutput("t4_fea",   64'(feaV[0]),   64'h0004);
        checkOutput("t4_fep",   64'(fepV[0]),   64'd0);
        checkOutput("t4_txns",  64'(txnCnt[0]), 64'd48);
        checkOutput("t4_req_stable", 64'(protoErr), 64'd0);
        checkOutput("t4_one_gap",    64'(gapErr),   64'd0);
        maxDelay = 0;
        failTxn  = -1;

        $display("[TB] reset mid pass 2, then restart without clearing memory");
        memCmd = 0;
        applyStimulus(0);
        stopWait = 1'b0;
        for (int n = 0; n < 500 && !stopWait; n++) begin
            @(negedge clk);
            #1 stopWait = reqV[0] && (txnCnt[0] >= 28);
        end
        checkOutput("t5_reached_pass2", 64'(stopWait), 64'd1);
        rst_L = 1'b0;
        #1;
        checkOutput("t5_req_async",  64'(reqV[0]),   64'd0);
        checkOutput("t5_busy_async", 64'(busyV[0]),  64'd0);
        checkOutput("t5_err_async",  64'(errV[0]),   64'd0);
        checkOutput("t5_phase_async", 64'(phaseV[0]), 64'hF);
        @(negedge clk);
        rst_L = 1'b1;
        applyStimulus(0);
        waitDone(0, cyc);
        checkOutput("t5_cycles", 64'(cyc),       64'd96);
        checkOutput("t5_err",    64'(errV[0]),   64'd8);
        checkOutput("t5_phase",  64'(phaseV[0]), 64'hE);
        checkOutput("t5_fea",    64'(feaV[0]),   64'h0000);
        checkOutput("t5_fep",    64'(fepV[0]),   64'd0);

`ifdef USB_MEM_BIST_TIMEOUT_EN
        $display("[TB] watchdog, address 0x0012 never acked");
        memCmd = 1;
        toSeen = 0;
        applyStimulus(2);
        waitDone(2, cyc);
        checkOutput("t6_cycles",  64'(cyc),       64'd114);
        checkOutput("t6_err",     64'(errV[2]),   64'd6);
        checkOutput("t6_phase",   64'(phaseV[2]), 64'h0);
        checkOutput("t6_fea",     64'(feaV[2]),   64'h0012);
        checkOutput("t6_fep",     64'(fepV[2]),   64'd0);
        checkOutput("t6_drops",   64'(toSeen),    64'd6);
        checkOutput("t6_drop_len", 64'(toErr),    64'd0);
        lateAck(2);
        checkOutput("t6_late_err",  64'(errV[2]),  64'd6);
        checkOutput("t6_late_done", 64'(doneV[2]), 64'd1);
        checkOutput("t6_late_req",  64'(reqV[2]),  64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
